// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: KSA state encoding, S-memory geometry and port widths.
// Used by the key schedule, the decrypt stage and the top-level memory mux.
package rc4_pkg;

    localparam int unsigned S_DEPTH           = 256;
    localparam int unsigned KEY_BYTES_DEFAULT = 3;
    localparam int unsigned S_ADDR_W          = 8;
    localparam int unsigned S_DATA_W          = 8;

    typedef enum logic [3:0] {
        KSA_IDLE,
        KSA_INIT,
        KSA_READ_I,
        KSA_READ_I_WAIT,
        KSA_COMPUTE_J,
        KSA_READ_J,
        KSA_READ_J_WAIT,
        KSA_WRITE_J,
        KSA_WRITE_I,
        KSA_NEXT_I,
        KSA_DONE
    } ksa_state_t;

    // One S-memory port request as driven by either RC4 stage.
    typedef struct packed {
        logic [S_ADDR_W-1:0] addr;
        logic [S_DATA_W-1:0] wdata;
        logic                we;
    } s_req_t;

    // Width of a counter over n key bytes; never narrower than one bit.
    function automatic int unsigned kx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc4_key_schedule_if.sv
// Control, key and S-memory port bundle of the RC4 key schedule.
// master: top level / RAM side; slave: the key schedule itself.
interface rc4_key_schedule_if #(
    parameter int unsigned KEY_BYTES = rc4_pkg::KEY_BYTES_DEFAULT
);

    logic                          start;
    logic [8*KEY_BYTES-1:0]        secret_key;
    logic [rc4_pkg::S_DATA_W-1:0]  s_read_data;
    logic [rc4_pkg::S_ADDR_W-1:0]  s_address;
    logic [rc4_pkg::S_DATA_W-1:0]  s_write_data;
    logic                          s_write;
    logic                          busy;
    logic                          finish;

    modport master (
        output start,
        output secret_key,
        output s_read_data,
        input  s_address,
        input  s_write_data,
        input  s_write,
        input  busy,
        input  finish
    );

    modport slave (
        input  start,
        input  secret_key,
        input  s_read_data,
        output s_address,
        output s_write_data,
        output s_write,
        output busy,
        output finish
    );

endinterface

// File: rtl/rc4_key_byte_sel.sv
// Registered key-byte mux: selects key byte kx (byte 0 = most significant)
// one cycle ahead so the byte is stable when j is computed.
module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_BYTES = KEY_BYTES_DEFAULT,
    parameter int unsigned KX_W      = kx_width(KEY_BYTES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic [KX_W-1:0]        kx_i,
    input  logic [8*KEY_BYTES-1:0] key_i,
    output logic [7:0]             key_byte_o
);

    logic [7:0] key_byte_q;
    logic [7:0] key_byte_d;

    always_comb begin
        key_byte_d = key_byte_q;
        if (load_i) begin
            key_byte_d = '0;
            for (int b = 0; b < int'(KEY_BYTES); b++) begin
                if (kx_i == KX_W'(b)) begin
                    key_byte_d = key_i[8*(int'(KEY_BYTES)-1-b) +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_byte_q <= '0;
        end else begin
            key_byte_q <= key_byte_d;
        end
    end

    assign key_byte_o = key_byte_q;

endmodule

// File: rtl/rc4_key_schedule.sv
// RC4 key schedule: fills S with the identity permutation, then runs the KSA
// swap loop over the shared single-port S memory (read data valid in the *_WAIT state).
module rc4_key_schedule
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_BYTES = KEY_BYTES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    rc4_key_schedule_if.slave  bus
);

    localparam int unsigned KX_W = kx_width(KEY_BYTES);

    ksa_state_t            state_q, state_d;
    logic [S_ADDR_W-1:0]   i_q, i_d;
    logic [S_ADDR_W-1:0]   j_q, j_d;
    logic [KX_W-1:0]       kx_q, kx_d;
    logic [S_DATA_W-1:0]   si_q, si_d;
    logic [S_DATA_W-1:0]   sj_q, sj_d;

    logic [KX_W-1:0]       kx_next;
    logic [KX_W-1:0]       key_sel;
    logic                  key_load;
    logic [7:0]            key_byte;
    s_req_t                req;

    // Wrapping key index; avoids a modulo divider.
    assign kx_next = (kx_q == KX_W'(KEY_BYTES - 1)) ? '0 : kx_q + KX_W'(1);

    rc4_key_byte_sel #(
        .KEY_BYTES (KEY_BYTES),
        .KX_W      (KX_W)
    ) u_key_byte_sel (
        .clk        (clk),
        .reset      (reset),
        .load_i     (key_load),
        .kx_i       (key_sel),
        .key_i      (bus.secret_key),
        .key_byte_o (key_byte)
    );

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        kx_d     = kx_q;
        si_d     = si_q;
        sj_d     = sj_q;
        key_load = 1'b0;
        key_sel  = kx_q;
        req      = '0;

        case (state_q)
            KSA_IDLE: begin
                key_load = 1'b1;
                key_sel  = '0;
                if (bus.start) begin
                    state_d = KSA_INIT;
                    i_d     = '0;
                    j_d     = '0;
                    kx_d    = '0;
                end
            end
            KSA_INIT: begin
                req.addr  = i_q;
                req.wdata = i_q;
                req.we    = 1'b1;
                i_d       = i_q + S_ADDR_W'(1);
                if (i_q == S_ADDR_W'(S_DEPTH - 1)) begin
                    state_d = KSA_READ_I;
                end
            end
            KSA_READ_I: begin
                req.addr = i_q;
                state_d  = KSA_READ_I_WAIT;
            end
            KSA_READ_I_WAIT: begin
                req.addr = i_q;
                si_d     = bus.s_read_data;
                state_d  = KSA_COMPUTE_J;
            end
            KSA_COMPUTE_J: begin
                j_d     = j_q + si_q + key_byte;
                state_d = KSA_READ_J;
            end
            KSA_READ_J: begin
                req.addr = j_q;
                state_d  = KSA_READ_J_WAIT;
            end
            KSA_READ_J_WAIT: begin
                req.addr = j_q;
                sj_d     = bus.s_read_data;
                state_d  = KSA_WRITE_J;
            end
            KSA_WRITE_J: begin
                req.addr  = j_q;
                req.wdata = si_q;
                req.we    = 1'b1;
                state_d   = KSA_WRITE_I;
            end
            KSA_WRITE_I: begin
                // With i==j, sj equals si, so the second write leaves S[i] intact.
                req.addr  = i_q;
                req.wdata = sj_q;
                req.we    = 1'b1;
                state_d   = KSA_NEXT_I;
            end
            KSA_NEXT_I: begin
                if (i_q == S_ADDR_W'(S_DEPTH - 1)) begin
                    state_d = KSA_DONE;
                end else begin
                    i_d      = i_q + S_ADDR_W'(1);
                    kx_d     = kx_next;
                    key_load = 1'b1;
                    key_sel  = kx_next;
                    state_d  = KSA_READ_I;
                end
            end
            KSA_DONE: begin
                state_d = KSA_IDLE;
            end
            default: begin
                state_d = KSA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= KSA_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            kx_q    <= '0;
            si_q    <= '0;
            sj_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            kx_q    <= kx_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

    assign bus.s_address    = req.addr;
    assign bus.s_write_data = req.wdata;
    assign bus.s_write      = req.we;
    assign bus.busy         = (state_q != KSA_IDLE);
    assign bus.finish       = (state_q == KSA_DONE);

endmodule

// File: tb/tb_rc4_key_schedule.sv
// Directed bench for rc4_key_schedule with a synchronous-read S RAM model
// and a software RC4 KSA reference.
module tb_rc4_key_schedule;
    import rc4_pkg::*;

    localparam int unsigned KB        = 3;
    localparam int          TRACE_LEN = 2310;

    logic clk = 1'b0;
    logic reset;

    rc4_key_schedule_if #(.KEY_BYTES(KB)) bus ();

    rc4_key_schedule #(.KEY_BYTES(KB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] rd_q;

    always @(posedge clk) begin
        if (bus.s_write) mem[bus.s_address] <= bus.s_write_data;
        rd_q <= mem[bus.s_address];
    end
    assign bus.s_read_data = rd_q;

    int checks = 0;
    int errors = 0;

    logic       tr_we   [0:TRACE_LEN];
    logic [7:0] tr_addr [0:TRACE_LEN];
    logic [7:0] tr_data [0:TRACE_LEN];
    logic       tr_busy [0:TRACE_LEN];
    logic       tr_fin  [0:TRACE_LEN];
    logic [7:0] snap    [256];
    logic [7:0] golden  [256];

    // Software RC4 KSA over 3 key bytes, byte 0 most significant.
    task automatic ksa_model(input logic [23:0] key);
        logic [7:0] jj;
        logic [7:0] t;
        logic [7:0] kb;
        for (int k = 0; k < 256; k++) golden[k] = 8'(k);
        jj = 8'd0;
        for (int ii = 0; ii < 256; ii++) begin
            kb = key[8*(2 - (ii % 3)) +: 8];
            jj = jj + golden[ii] + kb;
            t = golden[ii];
            golden[ii] = golden[jj];
            golden[jj] = t;
        end
    endtask

    // Pulses (or holds) start and records outputs at cycles t+1..t+TRACE_LEN.
    task automatic capture(input bit hold);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= TRACE_LEN; n++) begin
            @(negedge clk);
            if (n == 1 && !hold) bus.start = 1'b0;
            tr_we[n]   = bus.s_write;
            tr_addr[n] = bus.s_address;
            tr_data[n] = bus.s_write_data;
            tr_busy[n] = bus.busy;
            tr_fin[n]  = bus.finish;
            if (n == 257) for (int k = 0; k < 256; k++) snap[k] = mem[k];
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.secret_key = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.s_write !== 1'b0) begin errors++; $display("FAIL reset_s_write got %b want 0", bus.s_write); end
        checks++;
        if (bus.finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b want 0", bus.finish); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++;
        if (bus.s_address !== 8'h00) begin errors++; $display("FAIL reset_s_address got %h want 00", bus.s_address); end
        checks++;
        if (bus.s_write_data !== 8'h00) begin errors++; $display("FAIL reset_s_write_data got %h want 00", bus.s_write_data); end
        reset = 1'b0;
    endtask

    task automatic test_init_fill();
        int wcount;
        int bad;
        int bad_snap;
        bus.secret_key = 24'h000000;
        capture(1'b0);
        wcount = 0;
        bad = 0;
        for (int n = 1; n <= 256; n++) begin
            if (tr_we[n] === 1'b1) wcount++;
            if (tr_addr[n] !== 8'(n - 1) || tr_data[n] !== 8'(n - 1)) bad++;
        end
        checks++;
        if (wcount !== 256) begin errors++; $display("FAIL init_write_count got %0d want 256", wcount); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL init_addr_data bad_cycles %0d want 0", bad); end
        bad_snap = 0;
        for (int k = 0; k < 256; k++) if (snap[k] !== 8'(k)) bad_snap++;
        checks++;
        if (bad_snap !== 0) begin errors++; $display("FAIL init_fill_contents bad_entries %0d want 0", bad_snap); end
    endtask

    // Uses the key=0 trace captured by test_init_fill.
    task automatic test_self_swap();
        int cyc [6];
        logic [7:0] ea [6];
        logic [7:0] ed [6];
        int bad;
        int off;
        cyc = '{262, 263, 270, 271, 278, 279};
        ea  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2};
        ed  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
        for (int m = 0; m < 6; m++) begin
            checks++;
            if ({tr_we[cyc[m]], tr_addr[cyc[m]], tr_data[cyc[m]]} !== {1'b1, ea[m], ed[m]}) begin
                errors++;
                $display("FAIL self_swap_write%0d got we=%b addr=%0d data=%0d want we=1 addr=%0d data=%0d",
                         m, tr_we[cyc[m]], tr_addr[cyc[m]], tr_data[cyc[m]], ea[m], ed[m]);
            end
        end
        bad = 0;
        for (int n = 257; n <= 2304; n++) begin
            off = (n - 257) % 8;
            if (tr_we[n] !== ((off == 5 || off == 6) ? 1'b1 : 1'b0)) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL ksa_write_pattern bad_cycles %0d want 0", bad); end
        ksa_model(24'h000000);
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== golden[k]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL ksa_key0_state bad_entries %0d want 0", bad); end
    endtask

    task automatic test_full_ksa();
        int bad;
        int fin_count;
        int fin_cyc;
        bus.secret_key = 24'h000249;
        capture(1'b0);
        ksa_model(24'h000249);
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== golden[k]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL full_ksa_state bad_entries %0d want 0", bad); end
        fin_count = 0;
        fin_cyc = -1;
        for (int n = 1; n <= TRACE_LEN; n++) begin
            if (tr_fin[n] === 1'b1) begin
                fin_count++;
                if (fin_cyc < 0) fin_cyc = n;
            end
        end
        checks++;
        if (fin_cyc !== 2305) begin errors++; $display("FAIL finish_cycle got t+%0d want t+2305", fin_cyc); end
        checks++;
        if (fin_count !== 1) begin errors++; $display("FAIL finish_pulses got %0d want 1", fin_count); end
        checks++;
        if ({tr_busy[1], tr_busy[2305], tr_busy[2306]} !== 3'b110) begin
            errors++;
            $display("FAIL busy_window got t+1=%b t+2305=%b t+2306=%b want 1 1 0",
                     tr_busy[1], tr_busy[2305], tr_busy[2306]);
        end
    endtask

    // Uses the key=0x000249 trace: j at iterations 0..5 exercises key bytes 0,1,2,0,1,2.
    task automatic test_key_wrap();
        logic [7:0] ej [6];
        int c;
        ej = '{8'd0, 8'd3, 8'd78, 8'd79, 8'd85, 8'd163};
        for (int m = 0; m < 6; m++) begin
            c = 262 + 8 * m;
            checks++;
            if ({tr_we[c], tr_addr[c]} !== {1'b1, ej[m]}) begin
                errors++;
                $display("FAIL key_wrap_j%0d got we=%b j=%0d want we=1 j=%0d", m, tr_we[c], tr_addr[c], ej[m]);
            end
        end
    endtask

    task automatic test_start_held();
        int fin_count;
        bus.secret_key = 24'h000249;
        capture(1'b1);
        bus.start = 1'b0;
        fin_count = 0;
        for (int n = 1; n <= 2306; n++) if (tr_fin[n] === 1'b1) fin_count++;
        checks++;
        if (fin_count !== 1) begin errors++; $display("FAIL held_finish_pulses got %0d want 1", fin_count); end
        checks++;
        if ({tr_busy[2306], tr_we[2306]} !== 2'b00) begin
            errors++;
            $display("FAIL held_idle_gap got busy=%b we=%b want 0 0", tr_busy[2306], tr_we[2306]);
        end
        checks++;
        if ({tr_busy[2307], tr_we[2307], tr_addr[2307], tr_data[2307]} !== {1'b1, 1'b1, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL held_restart_init got busy=%b we=%b addr=%0d data=%0d want 1 1 0 0",
                     tr_busy[2307], tr_we[2307], tr_addr[2307], tr_data[2307]);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int bad;
        int fin_cyc;
        bus.secret_key = 24'h000249;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 2; n <= 1062; n++) @(negedge clk);
        checks++;
        if (bus.s_write !== 1'b1) begin errors++; $display("FAIL midrun_in_write_j got s_write=%b want 1", bus.s_write); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.s_write, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL midrun_reset_outputs got we=%b busy=%b want 0 0", bus.s_write, bus.busy);
        end
        checks++;
        if (dut.state_q !== KSA_IDLE) begin errors++; $display("FAIL midrun_reset_state got %0d want %0d", dut.state_q, KSA_IDLE); end
        reset = 1'b0;
        capture(1'b0);
        ksa_model(24'h000249);
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== golden[k]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rerun_state bad_entries %0d want 0", bad); end
        fin_cyc = -1;
        for (int n = TRACE_LEN; n >= 1; n--) if (tr_fin[n] === 1'b1) fin_cyc = n;
        checks++;
        if (fin_cyc !== 2305) begin errors++; $display("FAIL rerun_finish_cycle got t+%0d want t+2305", fin_cyc); end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 8'hA5;
        test_reset();
        test_init_fill();
        test_self_swap();
        test_full_ksa();
        test_key_wrap();
        test_start_held();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
